// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller:
// FSM states, forward-select codes and the shadow entry.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [3:0] dst;
    logic       load;
  } shEntry_t;

  function automatic logic srcHit(
    input logic [3:0] addr,
    input logic       en,
    input shEntry_t   e
  );
    return e.valid & (e.dst == addr) & en;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the ID stage and the
// hazard controller.
interface pipe_hazard_ctrl_if;
  logic [3:0] i_rdReg1;
  logic [3:0] i_rdReg2;
  logic       i_rdReg1En;
  logic       i_rdReg2En;
  logic [3:0] i_wrReg;
  logic       i_wrRegEn;
  logic       i_memRd;
  logic       i_sawBr;
  logic       i_sawJ;
  logic       i_hlt;
  logic       o_stall;
  logic       o_flush;
  logic [1:0] o_fwdSel1;
  logic [1:0] o_fwdSel2;
  logic       o_halted;

  modport master (
    output i_rdReg1, i_rdReg2, i_rdReg1En, i_rdReg2En,
    output i_wrReg, i_wrRegEn, i_memRd,
    output i_sawBr, i_sawJ, i_hlt,
    input  o_stall, o_flush, o_fwdSel1, o_fwdSel2,
    input  o_halted
  );

  modport slave (
    input  i_rdReg1, i_rdReg2, i_rdReg1En, i_rdReg2En,
    input  i_wrReg, i_wrRegEn, i_memRd,
    input  i_sawBr, i_sawJ, i_hlt,
    output o_stall, o_flush, o_fwdSel1, o_fwdSel2,
    output o_halted
  );
endinterface

// File: rtl/pipe_shadow_reg.sv
// Shadow copy of in-flight writes in EX, MEM and WB;
// a bubble enters EX whenever nothing issues.
module pipe_shadow_reg
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     issue,
  input  shEntry_t newEnt,
  output shEntry_t shEx,
  output shEntry_t shMem,
  output shEntry_t shWb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      shEx  <= '0;
      shMem <= '0;
      shWb  <= '0;
    end else begin
      shEx  <= issue ? newEnt : '0;
      shMem <= shEx;
      shWb  <= shMem;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush, forward-select and halt-drain control
// for the five-stage core.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit FWD       = 1'b1,
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  pipe_hazard_ctrl_if.slave  bus
);

  state_t   state, stateNxt;
  shEntry_t shEx, shMem, shWb, newEnt;
  logic     hazard, issue, empty;
  logic     m1Ex, m2Ex, m1Mem, m2Mem, m1Wb, m2Wb;
  logic [1:0] sel1, sel2;

  assign m1Ex  = srcHit(bus.i_rdReg1, bus.i_rdReg1En, shEx);
  assign m2Ex  = srcHit(bus.i_rdReg2, bus.i_rdReg2En, shEx);
  assign m1Mem = srcHit(bus.i_rdReg1, bus.i_rdReg1En, shMem);
  assign m2Mem = srcHit(bus.i_rdReg2, bus.i_rdReg2En, shMem);
  assign m1Wb  = srcHit(bus.i_rdReg1, bus.i_rdReg1En, shWb);
  assign m2Wb  = srcHit(bus.i_rdReg2, bus.i_rdReg2En, shWb);

  always_comb begin
    hazard = 1'b0;
    if (FWD)
      hazard = (m1Ex | m2Ex) & shEx.load;
    else
      hazard = m1Ex | m2Ex | m1Mem | m2Mem;
    if (!RF_BYPASS)
      hazard = hazard | m1Wb | m2Wb;
  end

  // r0 is hard-wired, so writing it never produces a hazard
  assign newEnt = '{
    valid: bus.i_wrRegEn & (bus.i_wrReg != 4'd0),
    dst:   bus.i_wrReg,
    load:  bus.i_memRd
  };

  assign issue = (state == RUN) & ~hazard & ~bus.i_hlt;
  assign empty = ~(shEx.valid | shMem.valid | shWb.valid);

  pipe_shadow_reg uShadow (
    .clk    (i_clk),
    .rst    (i_rst),
    .issue  (issue),
    .newEnt (newEnt),
    .shEx   (shEx),
    .shMem  (shMem),
    .shWb   (shWb)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= RUN;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      RUN:     if (bus.i_hlt & ~hazard) stateNxt = DRAIN;
      DRAIN:   if (empty) stateNxt = HALTED;
      HALTED:  stateNxt = HALTED;
      default: stateNxt = RUN;
    endcase
  end

  always_comb begin
    bus.o_stall  = 1'b1;
    bus.o_flush  = 1'b0;
    bus.o_halted = 1'b0;
    unique case (state)
      RUN: begin
        bus.o_stall = hazard;
        bus.o_flush = (bus.i_sawBr | bus.i_sawJ) & ~hazard;
      end
      DRAIN:   bus.o_stall  = 1'b1;
      HALTED:  bus.o_halted = 1'b1;
      default: bus.o_stall  = 1'b1;
    endcase
  end

  // youngest producer wins: EX/MEM result before MEM/WB
  function automatic logic [1:0] pickSel(
    input logic hitEx,
    input logic hitMem
  );
    if (hitEx & ~shEx.load) return FWD_EXMEM;
    if (hitMem)             return FWD_MEMWB;
    return FWD_RF;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel1 <= FWD_RF;
      sel2 <= FWD_RF;
    end else if (FWD && issue) begin
      sel1 <= pickSel(m1Ex, m1Mem);
      sel2 <= pickSel(m2Ex, m2Mem);
    end else begin
      sel1 <= FWD_RF;
      sel2 <= FWD_RF;
    end
  end

  assign bus.o_fwdSel1 = sel1;
  assign bus.o_fwdSel2 = sel2;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three controller configurations fed
// the same decode stream, checked once per cycle.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] r1, r2, w;
  logic e1, e2, we, ld, br, j, hlt;
  logic [18:0] stim;
  assign stim = {r1, e1, r2, e2, w, we, ld, br, j, hlt};

  pipe_hazard_ctrl_if ifA ();
  pipe_hazard_ctrl_if ifB ();
  pipe_hazard_ctrl_if ifC ();

  assign {ifA.i_rdReg1, ifA.i_rdReg1En, ifA.i_rdReg2,
          ifA.i_rdReg2En, ifA.i_wrReg, ifA.i_wrRegEn,
          ifA.i_memRd, ifA.i_sawBr, ifA.i_sawJ,
          ifA.i_hlt} = stim;
  assign {ifB.i_rdReg1, ifB.i_rdReg1En, ifB.i_rdReg2,
          ifB.i_rdReg2En, ifB.i_wrReg, ifB.i_wrRegEn,
          ifB.i_memRd, ifB.i_sawBr, ifB.i_sawJ,
          ifB.i_hlt} = stim;
  assign {ifC.i_rdReg1, ifC.i_rdReg1En, ifC.i_rdReg2,
          ifC.i_rdReg2En, ifC.i_wrReg, ifC.i_wrRegEn,
          ifC.i_memRd, ifC.i_sawBr, ifC.i_sawJ,
          ifC.i_hlt} = stim;

  pipe_hazard_ctrl #(.FWD(1'b1), .RF_BYPASS(1'b1)) dA (
    .i_clk(clk), .i_rst(rst), .bus(ifA));
  pipe_hazard_ctrl #(.FWD(1'b0), .RF_BYPASS(1'b1)) dB (
    .i_clk(clk), .i_rst(rst), .bus(ifB));
  pipe_hazard_ctrl #(.FWD(1'b0), .RF_BYPASS(1'b0)) dC (
    .i_clk(clk), .i_rst(rst), .bus(ifC));

  typedef struct {
    int         step;
    int         dut;
    logic       st;
    logic       fl;
    logic [1:0] s1;
    logic [1:0] s2;
    logic       h;
  } exp_t;

  exp_t q[$];
  int   nChk = 0;
  int   nPass = 0;
  int   stepN = 0;

  task automatic chk(input string nm, input int s,
                     input int d, input logic [1:0] got,
                     input logic [1:0] want);
    nChk++;
    if (got === want) nPass++;
    else $display("FAIL %s step%0d dut%0d got %0d want %0d",
                  nm, s, d, got, want);
  endtask

  function automatic logic [6:0] getOut(input int d);
    case (d)
      0: return {ifA.o_stall, ifA.o_flush, ifA.o_fwdSel1,
                 ifA.o_fwdSel2, ifA.o_halted};
      1: return {ifB.o_stall, ifB.o_flush, ifB.o_fwdSel1,
                 ifB.o_fwdSel2, ifB.o_halted};
      default: return {ifC.o_stall, ifC.o_flush,
                       ifC.o_fwdSel1, ifC.o_fwdSel2,
                       ifC.o_halted};
    endcase
  endfunction

  exp_t       mE;
  logic [6:0] mG;
  always @(negedge clk) begin
    while (q.size() > 0) begin
      mE = q.pop_front();
      mG = getOut(mE.dut);
      chk("stall", mE.step, mE.dut, {1'b0, mG[6]}, {1'b0, mE.st});
      chk("flush", mE.step, mE.dut, {1'b0, mG[5]}, {1'b0, mE.fl});
      chk("sel1", mE.step, mE.dut, mG[4:3], mE.s1);
      chk("sel2", mE.step, mE.dut, mG[2:1], mE.s2);
      chk("halted", mE.step, mE.dut, {1'b0, mG[0]}, {1'b0, mE.h});
    end
  end

  task automatic drv(input logic [3:0] a1, input logic a1e,
                     input logic [3:0] a2, input logic a2e,
                     input logic [3:0] aw, input logic awe,
                     input logic ald, input logic abr,
                     input logic aj, input logic ahlt);
    r1 = a1; e1 = a1e; r2 = a2; e2 = a2e;
    w = aw; we = awe; ld = ald;
    br = abr; j = aj; hlt = ahlt;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic exp(input int d, input logic st,
                     input logic fl, input logic [1:0] s1,
                     input logic [1:0] s2, input logic h);
    exp_t e;
    e = '{stepN, d, st, fl, s1, s2, h};
    q.push_back(e);
  endtask

  task automatic expAll(input logic st, input logic fl,
                        input logic h);
    for (int d = 0; d < 3; d++) exp(d, st, fl, 0, 0, h);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    stepN++;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    tick();
    expAll(0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    doReset();

    // load-use, ALU chain and youngest-producer on dA
    drv(0, 0, 0, 0, 3, 1, 1, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(3, 1, 5, 1, 4, 1, 0, 0, 0, 0); exp(0, 1, 0, 0, 0, 0); tick();
    drv(3, 1, 5, 1, 4, 1, 0, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 2, 1, 0, 0, 0, 0); exp(0, 0, 0, 2, 0, 0); tick();
    drv(2, 1, 2, 1, 6, 1, 0, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    idle();                            exp(0, 0, 0, 1, 1, 0); tick();
    drv(0, 0, 0, 0, 2, 1, 0, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 2, 1, 0, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(2, 1, 0, 0, 0, 0, 0, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    idle();                            exp(0, 0, 0, 1, 0, 0); tick();

    // r0 load writer then r0 reader: never a hazard
    drv(0, 0, 0, 0, 0, 1, 1, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0); expAll(0, 0, 0); tick();
    idle();                            exp(0, 0, 0, 0, 0, 0); tick();

    // no forwarding: 2 stalls with bypass, 3 without
    doReset();
    drv(0, 0, 0, 0, 2, 1, 0, 0, 0, 0); expAll(0, 0, 0); tick();
    drv(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    exp(0, 0, 0, 0, 0, 0); exp(1, 1, 0, 0, 0, 0);
    exp(2, 1, 0, 0, 0, 0); tick();
    exp(0, 0, 0, 1, 0, 0); exp(1, 1, 0, 0, 0, 0);
    exp(2, 1, 0, 0, 0, 0); tick();
    exp(0, 0, 0, 2, 0, 0); exp(1, 0, 0, 0, 0, 0);
    exp(2, 1, 0, 0, 0, 0); tick();
    expAll(0, 0, 0); tick();

    // branch behind a load-use stall, then a jump
    doReset();
    drv(0, 0, 0, 0, 3, 1, 1, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(3, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    exp(0, 1, 0, 0, 0, 0); exp(1, 1, 0, 0, 0, 0);
    exp(2, 1, 0, 0, 0, 0); tick();
    exp(0, 0, 1, 0, 0, 0); exp(1, 1, 0, 0, 0, 0);
    exp(2, 1, 0, 0, 0, 0); tick();
    idle();                            exp(0, 0, 0, 2, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp(0, 0, 1, 0, 0, 0); tick();
    idle();                            exp(0, 0, 0, 0, 0, 0); tick();

    // HLT behind three writers, drain, then reset pulse
    doReset();
    drv(0, 0, 0, 0, 1, 1, 0, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 2, 1, 0, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 3, 1, 0, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expAll(0, 0, 0); tick();
    expAll(1, 0, 0); tick();
    expAll(1, 0, 0); tick();
    expAll(1, 0, 0); tick();
    expAll(1, 0, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); expAll(1, 0, 1); tick();
    rst = 1'b1;
    idle();                            expAll(1, 0, 1); tick();
    rst = 1'b0;
    expAll(0, 0, 0); tick();

    // HLT that hazards waits in RUN
    drv(0, 0, 0, 0, 3, 1, 1, 0, 0, 0); exp(0, 0, 0, 0, 0, 0); tick();
    drv(3, 1, 0, 0, 0, 0, 0, 0, 0, 1); exp(0, 1, 0, 0, 0, 0); tick();
    exp(0, 0, 0, 0, 0, 0); tick();
    exp(0, 1, 0, 0, 0, 0); tick();
    idle();
    tick();

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      nChk++;
      $display("FAIL scoreboard left %0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
